// File: rtl/chip8_keypad_decoder_if.sv
// ---------------------------------------------------------------------------
// chip8_keypad_decoder_if
// Groups the PS/2 byte stream and the key-event queue handshake.
//   scan_valid : one-cycle pulse, scan_data valid this cycle
//   scan_data  : PS/2 scan-code byte
//   ev_pop     : consume the head event (ignored when ev_valid=0)
//   ev_valid   : event queue non-empty
//   ev_key     : key index of the head event
//   ev_pressed : 1 = press, 0 = release (head event)
// master = byte source / event consumer, slave = the decoder.
// ---------------------------------------------------------------------------
interface chip8_keypad_decoder_if;
  logic       scan_valid;
  logic [7:0] scan_data;
  logic       ev_pop;
  logic       ev_valid;
  logic [3:0] ev_key;
  logic       ev_pressed;

  modport master (
    output scan_valid, scan_data, ev_pop,
    input  ev_valid, ev_key, ev_pressed
  );

  modport slave (
    input  scan_valid, scan_data, ev_pop,
    output ev_valid, ev_key, ev_pressed
  );
endinterface

// File: rtl/chip8_keypad_decoder.sv
// ---------------------------------------------------------------------------
// chip8_keypad_decoder
// Decodes PS/2 set-2 scan bytes into the 16-key Chip-8 matrix and queues
// press/release events in a first-word fall-through FIFO.
//   i_clk        : system clock, all state changes on the rising edge
//   i_reset      : synchronous, active-high reset
//   i_clear      : synchronous bulk clear, same effect as reset
//   bus          : scan byte input and event queue handshake (slave side)
//   o_key_matrix : bit k = Chip-8 key k held
//   o_any_key    : OR of o_key_matrix, registered alongside it
//   o_overflow   : sticky, an event was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module chip8_keypad_decoder #(
  parameter int FIFO_DEPTH    = 4,
  parameter int REPEAT_FILTER = 1,
  parameter int EXT_MAP       = 0
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_clear,
  chip8_keypad_decoder_if.slave   bus,
  output logic [15:0]             o_key_matrix,
  output logic                    o_any_key,
  output logic                    o_overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic FILTER_EN = (REPEAT_FILTER != 0);
  localparam logic EXT_EN    = (EXT_MAP != 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BRK     = 2'd1,
    S_EXT     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  // Scan code -> {hit, key}; hit=0 for codes outside the Chip-8 table.
  function automatic logic [4:0] map_key(input logic [7:0] code);
    case (code)
      8'h22:   map_key = 5'h10;
      8'h16:   map_key = 5'h11;
      8'h1E:   map_key = 5'h12;
      8'h26:   map_key = 5'h13;
      8'h15:   map_key = 5'h14;
      8'h1D:   map_key = 5'h15;
      8'h24:   map_key = 5'h16;
      8'h1C:   map_key = 5'h17;
      8'h1B:   map_key = 5'h18;
      8'h23:   map_key = 5'h19;
      8'h1A:   map_key = 5'h1A;
      8'h21:   map_key = 5'h1B;
      8'h25:   map_key = 5'h1C;
      8'h2D:   map_key = 5'h1D;
      8'h2B:   map_key = 5'h1E;
      8'h2A:   map_key = 5'h1F;
      default: map_key = 5'h00;
    endcase
  endfunction

  // Protocol/status bytes (BAT, ACK, echo, resend, errors) are never keys.
  function automatic logic is_special(input logic [7:0] code);
    case (code)
      8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hEE, 8'hFE: is_special = 1'b1;
      default:                                  is_special = 1'b0;
    endcase
  endfunction

  state_t           r_state;
  state_t           w_state_next;
  logic [15:0]      r_key_matrix;
  logic             r_any_key;
  logic             r_overflow;
  logic [4:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic [4:0]       w_map;
  logic             w_special;
  logic             w_ev_req;
  logic             w_ev_pressed;
  logic [3:0]       w_ev_key;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_push_ok;
  logic [15:0]      w_matrix_next;

  assign w_map     = map_key(bus.scan_data);
  assign w_special = is_special(bus.scan_data);
  assign w_ev_key  = w_map[3:0];

  // Decoder state register.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Decoder next-state: moves only on a valid byte; special bytes force IDLE.
  always_comb begin
    w_state_next = r_state;
    if (bus.scan_valid && w_special) begin
      w_state_next = S_IDLE;
    end else if (bus.scan_valid) begin
      case (r_state)
        S_IDLE: begin
          if (bus.scan_data == 8'hF0) begin
            w_state_next = S_BRK;
          end else if (bus.scan_data == 8'hE0) begin
            w_state_next = S_EXT;
          end else begin
            w_state_next = S_IDLE;
          end
        end
        S_EXT: begin
          if (bus.scan_data == 8'hF0) begin
            w_state_next = S_EXT_BRK;
          end else begin
            w_state_next = S_IDLE;
          end
        end
        S_BRK, S_EXT_BRK: w_state_next = S_IDLE;
        default:          w_state_next = S_IDLE;
      endcase
    end else begin
      w_state_next = r_state;
    end
  end

  // Decoder outputs: a make/break request for a mapped key this cycle.
  always_comb begin
    w_ev_req     = 1'b0;
    w_ev_pressed = 1'b0;
    if (bus.scan_valid && !w_special) begin
      case (r_state)
        S_IDLE: begin
          if (bus.scan_data != 8'hF0 && bus.scan_data != 8'hE0) begin
            w_ev_req     = w_map[4];
            w_ev_pressed = 1'b1;
          end else begin
            w_ev_req     = 1'b0;
            w_ev_pressed = 1'b0;
          end
        end
        S_BRK: begin
          w_ev_req     = w_map[4];
          w_ev_pressed = 1'b0;
        end
        S_EXT: begin
          if (bus.scan_data != 8'hF0) begin
            w_ev_req     = w_map[4] & EXT_EN;
            w_ev_pressed = 1'b1;
          end else begin
            w_ev_req     = 1'b0;
            w_ev_pressed = 1'b0;
          end
        end
        S_EXT_BRK: begin
          w_ev_req     = w_map[4] & EXT_EN;
          w_ev_pressed = 1'b0;
        end
        default: begin
          w_ev_req     = 1'b0;
          w_ev_pressed = 1'b0;
        end
      endcase
    end else begin
      w_ev_req     = 1'b0;
      w_ev_pressed = 1'b0;
    end
  end

  // Matrix update and push decision; a filtered repeat pushes nothing.
  always_comb begin
    w_matrix_next = r_key_matrix;
    if (w_ev_req) begin
      w_matrix_next[w_ev_key] = w_ev_pressed;
    end else begin
      w_matrix_next = r_key_matrix;
    end
    if (FILTER_EN) begin
      w_push = w_ev_req && (r_key_matrix[w_ev_key] != w_ev_pressed);
    end else begin
      w_push = w_ev_req;
    end
  end

  assign w_pop  = bus.ev_pop && (r_count != {CNT_W{1'b0}});
  assign w_full = (r_count == DEPTH_C);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign w_push_ok = w_push && (!w_full || w_pop);

  // Key matrix, any-key flag and sticky overflow.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_key_matrix <= 16'h0000;
      r_any_key    <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_key_matrix <= w_matrix_next;
      r_any_key    <= |w_matrix_next;
      if (w_push && !w_push_ok) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Event FIFO storage, pointers and occupancy.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= 5'h00;
      end
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= {w_ev_pressed, w_ev_key};
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_key_matrix   = r_key_matrix;
  assign o_any_key      = r_any_key;
  assign o_overflow     = r_overflow;
  assign bus.ev_valid   = (r_count != {CNT_W{1'b0}});
  assign bus.ev_key     = r_mem[r_rd_ptr][3:0];
  assign bus.ev_pressed = r_mem[r_rd_ptr][4];

endmodule

// File: doc/chip8_keypad_decoder.md
Name: chip8_keypad_decoder

Overview:
- Replaces the ad-hoc, clocked-by-ready keyboard task with a synchronous PS/2 scan-code decoder on the CPU clock domain.
- Consumes byte pulses from the PS/2 receiver and maintains the 16-key Chip-8 matrix.
- Queues press/release events in a parametrised FIFO so the CPU can service Fx0A (wait-for-key) without missing short taps.
- Adds extended-code handling, auto-repeat filtering, error recovery and a bulk clear.

Parameters:
FIFO_DEPTH, 4, event FIFO entries; power of two, range 2..16
REPEAT_FILTER, 1, 1 = suppress make events for keys already held and break events for keys not held
EXT_MAP, 0, 1 = E0-prefixed codes decode through the same table; 0 = E0 sequences are consumed and ignored

Ports:
clk  in  1  system clock; all state changes on the rising edge
reset  in  1  synchronous, active-high
scan_valid  in  1  one-cycle pulse; scan_data is valid this cycle
scan_data  in  8  PS/2 scan-code byte
clear  in  1  synchronous: release all keys, flush FIFO, clear overflow, decoder to IDLE
key_matrix  out  16  bit k = Chip-8 key k held
any_key  out  1  OR of key_matrix (registered with it)
ev_valid  out  1  FIFO non-empty
ev_key  out  4  key index of head event
ev_pressed  out  1  1 = press, 0 = release (head event)
ev_pop  in  1  consume head event; ignored when ev_valid=0
overflow  out  1  sticky: an event was dropped because FIFO was full

Behaviour:
- Reset: key_matrix=0, any_key=0, ev_valid=0, ev_key=0, ev_pressed=0, overflow=0, FIFO pointers/count=0, FSM=IDLE.
- The clear input acts identically to reset.
- Decoder FSM: states IDLE, BRK, EXT, EXT_BRK. Transitions occur only on a cycle with scan_valid=1.
  - IDLE: F0 -> BRK; E0 -> EXT; any other byte is a make code -> IDLE.
  - BRK: the byte is a break code -> IDLE.
  - EXT: F0 -> EXT_BRK; else extended make -> IDLE.
  - EXT_BRK: extended break -> IDLE.
  - Bytes 00, FF, AA, FA, EE and FE are never decoded as keys. In any state they force IDLE with no matrix or FIFO effect.
- Key table (scan code -> key):
  - 22->0, 16->1, 1E->2, 26->3, 15->4, 1D->5, 24->6, 1C->7
  - 1B->8, 23->9, 1A->A, 21->B, 25->C, 2D->D, 2B->E, 2A->F
  - Unmapped codes: no effect.
  - Extended codes use the table only when EXT_MAP=1; otherwise they have no effect.
- Make/break of mapped key k, decided on scan_valid cycle N:
  - key_matrix[k] and any_key update at N+1.
  - An event {k, pressed} is pushed at edge N+1 unless REPEAT_FILTER=1 and key_matrix[k] already equals the new value (no push, matrix unchanged).
- FIFO behaviour:
  - First-word fall-through. ev_valid = (count!=0). ev_key/ev_pressed = the head entry, combinational from registered storage.
  - A push at edge N+1 gives ev_valid=1 during cycle N+1 if the FIFO was empty.
  - Pop: ev_pop=1 with ev_valid=1 advances the read pointer at the edge.
  - Simultaneous push and pop: both occur and count is unchanged. This holds when full as well: the pop frees a slot and the push is accepted with no overflow.
  - Push while full with no pop: event dropped, overflow<=1. overflow stays set until reset/clear; matrix update still happens.
  - Pointers wrap modulo FIFO_DEPTH; count width = clog2(FIFO_DEPTH)+1.
  - When empty, ev_key/ev_pressed hold the last head value (don't-care to consumers; bench checks only when ev_valid=1).
- Priority per cycle: reset > clear > scan decode. A scan_valid coinciding with clear is discarded.
- Reset or clear mid-sequence (e.g. after F0) returns the FSM to IDLE, so the next byte is treated as a make.
- Throughput: one byte per cycle is accepted back-to-back; no backpressure to the PS/2 receiver.

Test Plan:
- Reset, then bytes 1E, F0, 1E -> key_matrix=0x0004 one cycle after the 1E pulse. FIFO holds {2,press},{2,release}. Final key_matrix=0x0000, any_key=0.
- REPEAT_FILTER=1, bytes 2A, 2A, 2A (auto-repeat), then F0 2A -> exactly 2 events {F,1},{F,0}. Repeat with REPEAT_FILTER=0 -> 4 events.
- FIFO_DEPTH=4, with no pops, makes 16,1E,26,15,1D -> first 4 queued, 5th dropped. overflow=1, key_matrix=0x003E.
- FIFO full, and in the same cycle ev_pop=1 plus a new event pushed -> count stays 4, overflow stays 0, and the head advances to the next entry.
- EXT_MAP=0: E0 22, then E0 F0 22 -> no matrix change, no events. EXT_MAP=1, same bytes -> {0,press},{0,release}. Also F0, then reset, then 22 -> treated as a make (key_matrix=0x0001).
- Hold keys 1 and C, send AA mid-stream, then assert clear -> AA has no effect. clear gives key_matrix=0, ev_valid=0, overflow=0. The next byte 16 is decoded as a make of key 1.
